// File: rtl/neuron_mac_fp32.sv
// Serial fp32 multiply-accumulate for one neuron: bias + sum(x[i]*w[i]).
// Simplified arithmetic: denormals flush to zero, no Inf/NaN, truncating rounding.
module neuron_mac_fp32 #(
  parameter int unsigned NUM_INPUTS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  input  logic [31:0] w_in,
  output logic [31:0] mult_sum_out,
  output logic [31:0] counter,
  output logic        sum_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(NUM_INPUTS);
  localparam logic [30:0] MAG_MAX  = 31'h7F7FFFFF;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] bias_q, bias_d;
  logic [31:0] x_q, x_d;
  logic [31:0] w_q, w_d;
  logic [31:0] prod_q, prod_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    logic [22:0] m;
    int          e;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, MAG_MAX};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big, sml;
    logic [23:0] mb, ms, ms_al, norm;
    logic [24:0] sum;
    logic [7:0]  diff;
    logic [22:0] m;
    logic        found;
    int unsigned lz;
    int          e;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    mb    = (big[30:23] == 8'd0) ? 24'd0 : {1'b1, big[22:0]};
    ms    = (sml[30:23] == 8'd0) ? 24'd0 : {1'b1, sml[22:0]};
    diff  = big[30:23] - sml[30:23];
    ms_al = (diff >= 8'd26) ? 24'd0 : (ms >> diff);
    sum   = (big[31] == sml[31]) ? ({1'b0, mb} + {1'b0, ms_al}) : ({1'b0, mb} - {1'b0, ms_al});
    // Exact cancellation yields +0 regardless of operand signs.
    if (sum == 25'd0) return 32'd0;
    if (sum[24]) begin
      m = sum[23:1];
      e = int'(big[30:23]) + 1;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < 24; i++) begin
        if (!found) begin
          if (sum[23-i]) found = 1'b1;
          else lz = lz + 1;
        end
      end
      norm = sum[23:0] << lz;
      m    = norm[22:0];
      e    = int'(big[30:23]) - int'(lz);
    end
    if (e <= 0) return {big[31], 31'd0};
    if (e >= 255) return {big[31], MAG_MAX};
    return {big[31], e[7:0], m};
  endfunction

  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      bias_q  <= '0;
      x_q     <= '0;
      w_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bias_q  <= bias_d;
      x_q     <= x_d;
      w_q     <= w_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bias_d    = bias_q;
    x_d       = x_q;
    w_d       = w_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    sum_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bias_d  = bias;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        acc_d   = bias_q;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = x_in;
          w_d     = w_in;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        prod_d  = fp_mul(x_q, w_q);
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d   = fp_add(acc_q, prod_q);
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == CNT_LAST) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        sum_valid = 1'b1;
        // Counter drops to zero with LOAD so the downstream stage releases immediately.
        if (start) begin
          bias_d  = bias;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mult_sum_out = acc_q;
  assign counter      = 32'(cnt_q);

endmodule

// File: tb/tb_neuron_mac_fp32.sv
// Directed bench for neuron_mac_fp32 with a real-arithmetic reference model.
module tb_neuron_mac_fp32;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bias = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x_in = '0;
  logic [31:0] w_in = '0;
  logic [31:0] mult_sum_out;
  logic [31:0] counter;
  logic        sum_valid;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          hs_count = 0;
  bit          armed = 1'b0;
  logic [31:0] vx[N];
  logic [31:0] vw[N];
  logic [31:0] exp_partial[N+1];

  neuron_mac_fp32 #(.NUM_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
    .mult_sum_out(mult_sum_out), .counter(counter), .sum_valid(sum_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic real f2r(input logic [31:0] v);
    real r;
    int  e;
    if (v[30:23] == 8'd0) return 0.0;
    r = 1.0 + real'(v[22:0]) / 8388608.0;
    e = int'(v[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return v[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic        s;
    real         m;
    int          e;
    logic [22:0] f;
    s = (r < 0.0);
    m = s ? -r : r;
    if (m == 0.0) return {s, 31'd0};
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    e = e + 127;
    if (e <= 0) return {s, 31'd0};
    if (e >= 255) return {s, 31'h7F7FFFFF};
    f = 23'($rtoi((m - 1.0) * 8388608.0));
    return {s, e[7:0], f};
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
    real r;
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 32'd0;
    return r2f(r);
  endfunction

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) hs_count++;
  end

  // Checks the visible accumulator against the model whenever it is meaningful.
  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("cnt_le_n", 32'(counter <= 32'(N)), 32'd1);
      if (in_ready && counter <= 32'(N)) chk("acc_wait", mult_sum_out, exp_partial[counter]);
      if (sum_valid) begin
        chk("acc_done", mult_sum_out, exp_partial[N]);
        chk("cnt_done", counter, 32'(N));
      end
      if (in_ready && sum_valid) chk("ready_and_valid", 32'd1, 32'd0);
    end
  end

  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] exp_final,
                     input int gap, input int abort_after, input bit poke_start);
    int t0;
    int n;
    bit rdy;
    bit sv;
    armed = 1'b0;
    exp_partial[0] = b;
    for (int k = 0; k < N; k++) exp_partial[k+1] = m_add(exp_partial[k], m_mul(vx[k], vw[k]));
    chk({tag, "_model"}, exp_partial[N], exp_final);
    hs_count = 0;
    @(posedge clk); #1;
    start = 1'b1;
    bias  = b;
    @(posedge clk); #1;
    t0    = cyc;
    start = 1'b0;
    bias  = $urandom;
    armed = 1'b1;
    in_valid = 1'b1;
    x_in = vx[0];
    w_in = vw[0];
    @(negedge clk);
    chk({tag, "_load_cnt"}, counter, 32'd0);
    chk({tag, "_load_valid"}, {31'd0, sum_valid}, 32'd0);
    chk({tag, "_load_ready"}, {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      x_in = vx[k];
      w_in = vw[k];
      if (poke_start && k == 1) begin
        start = 1'b1;
        bias  = 32'hC0000000;
      end
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 50) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!rdy) begin
        chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (poke_start && k == 1) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (k == abort_after) begin
        @(posedge clk); #1;
        armed = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_acc"}, mult_sum_out, 32'd0);
        chk({tag, "_rst_cnt"}, counter, 32'd0);
        chk({tag, "_rst_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_rst_valid"}, {31'd0, sum_valid}, 32'd0);
        return;
      end
      if (gap > 0) begin
        in_valid = 1'b0;
        x_in = $urandom;
        w_in = $urandom;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    // Leftover valid data while busy/done must never be consumed.
    x_in = 32'h3F800000;
    w_in = 32'h3F800000;
    in_valid = (gap == 0);
    n = 0;
    sv = 1'b0;
    while (!sv && n < 50) begin
      @(negedge clk);
      sv = sum_valid;
      if (!sv) begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!sv) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (gap == 0 && !poke_start) chk({tag, "_latency"}, 32'(cyc - t0), 32'(1 + 3 * N));
    chk({tag, "_final"}, mult_sum_out, exp_final);
    chk({tag, "_count"}, counter, 32'(N));
    chk({tag, "_pairs"}, 32'(hs_count), 32'(N));
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_hold"}, mult_sum_out, exp_final);
  endtask

  task automatic set_case1();
    vx = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    vw = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_acc", mult_sum_out, 32'd0);
    chk("reset_cnt", counter, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_valid", {31'd0, sum_valid}, 32'd0);

    chk("pin_mul_sat", m_mul(32'h7F000000, 32'h40800000), 32'h7F7FFFFF);
    chk("pin_mul_denorm", m_mul(32'h00400000, 32'h3F800000), 32'h00000000);
    chk("pin_add_cancel", m_add(32'h3F800000, 32'hBF800000), 32'h00000000);
    chk("pin_add_renorm", m_add(32'h40400000, 32'hC0200000), 32'h3F000000);

    set_case1();
    run("c1", 32'h00000000, 32'h40A00000, 0, -1, 1'b0);

    vx = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000};
    vw = '{32'hBF800000, 32'h00000000, 32'h00000000, 32'h00000000};
    run("c2", 32'h3F800000, 32'h00000000, 0, -1, 1'b0);

    set_case1();
    run("c3", 32'h00000000, 32'h40A00000, 4, -1, 1'b0);

    vx = '{32'h7F000000, 32'h00000000, 32'h00400000, 32'h00000000};
    vw = '{32'h40800000, 32'h00000000, 32'h3F800000, 32'h00000000};
    run("c4", 32'h00000000, 32'h7F7FFFFF, 0, -1, 1'b0);

    set_case1();
    run("c5a", 32'h00000000, 32'h40A00000, 0, 1, 1'b0);
    run("c5b", 32'h00000000, 32'h40A00000, 0, -1, 1'b0);

    run("c6", 32'h00000000, 32'h40A00000, 0, -1, 1'b1);

    vx = '{32'h3F800000, 32'h40000000, 32'h3F800000, 32'h40000000};
    vw = '{32'hC0200000, 32'h3F400000, 32'hBF000000, 32'h3E800000};
    run("c7", 32'h40400000, 32'h40000000, 1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
